// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: cache geometry default,
// the NOP encoding presented on misses, and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

    localparam int unsigned LINES_DEFAULT = 16;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0020;

    typedef enum logic [0:0] {
        LOOKUP = 1'b0,
        MISS   = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_icache_array.sv
// Direct-mapped one-word-per-line tag/valid/data store: asynchronous lookup,
// synchronous refill write, valid bits cleared by the asynchronous reset.
module icache_array
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEFAULT,
    parameter int unsigned IDX_W = $clog2(LINES),
    parameter int unsigned TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_r  [LINES];
    logic [31:0]      data_r [LINES];

    // Valid bits: only state here that must be known after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage, written on refill only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_data;
        end
    end

    // Combinational lookup for the current PC.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = data_r[rd_index];
        if (valid_r[rd_index] && (tag_r[rd_index] == rd_tag)) begin
            rd_hit = 1'b1;
        end else begin
            rd_hit = 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage with a small direct-mapped instruction cache; stalls
// the PC on a miss, refills one word from memory and honours branch redirects.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        hit,
    output logic [31:0] addr_out,
    output logic [31:0] instruction_out
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    fetch_state_e     state_r;
    logic [31:0]      pc_r;
    logic             mem_req_r;
    logic [31:0]      mem_addr_r;
    logic             pend_valid_r;
    logic [31:0]      pend_target_r;

    logic [IDX_W-1:0] index_s;
    logic [TAG_W-1:0] tag_s;
    logic             arr_hit_s;
    logic [31:0]      arr_data_s;
    logic             wr_en_s;
    logic             hit_s;
    logic [31:0]      instr_s;

    assign index_s = pc_r[IDX_W+1:2];
    assign tag_s   = pc_r[31:IDX_W+2];

    // The PC does not move during MISS, so it also names the line being refilled.
    icache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (index_s),
        .rd_tag   (tag_s),
        .rd_hit   (arr_hit_s),
        .rd_data  (arr_data_s),
        .wr_en    (wr_en_s),
        .wr_index (index_s),
        .wr_tag   (tag_s),
        .wr_data  (mem_rdata)
    );

    // Hit qualification, refill write enable and the NOP substitution.
    always_comb begin
        hit_s   = 1'b0;
        wr_en_s = 1'b0;
        instr_s = NOP_INSTR;
        if (state_r == LOOKUP) begin
            hit_s = arr_hit_s;
        end else begin
            wr_en_s = mem_ack;
        end
        if (hit_s) begin
            instr_s = arr_data_s;
        end else begin
            instr_s = NOP_INSTR;
        end
    end

    // Fetch FSM: PC sequencing, refill request and pending-redirect bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= LOOKUP;
            pc_r          <= 32'h0000_0000;
            mem_req_r     <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                LOOKUP: begin
                    if (branch_taken) begin
                        pc_r <= branch_target;
                    end else if (!hit_s) begin
                        // A miss is started even under stall; stall only holds the PC.
                        state_r    <= MISS;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= word_align(pc_r);
                    end else if (!stall) begin
                        pc_r <= pc_r + 32'd4;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                MISS: begin
                    if (mem_ack) begin
                        state_r      <= LOOKUP;
                        mem_req_r    <= 1'b0;
                        pend_valid_r <= 1'b0;
                        if (branch_taken) begin
                            pc_r <= branch_target;
                        end else if (pend_valid_r) begin
                            pc_r <= pend_target_r;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else if (branch_taken) begin
                        pend_valid_r  <= 1'b1;
                        pend_target_r <= branch_target;
                    end else begin
                        pend_valid_r <= pend_valid_r;
                    end
                end
                default: begin
                    state_r   <= LOOKUP;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req         = mem_req_r;
    assign mem_addr        = mem_addr_r;
    assign hit             = hit_s;
    assign addr_out        = pc_r;
    assign instruction_out = instr_s;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit (LINES=16): each row is
// one clock cycle of inputs plus the outputs expected during that cycle.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        hit;
    logic [31:0] addr_out;
    logic [31:0] instruction_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        st;
        bit        br;
        bit [31:0] tgt;
        bit        ack;
        bit [31:0] rd;
        bit        e_hit;
        bit [31:0] e_addr;
        bit [31:0] e_instr;
        bit        e_req;
        bit [31:0] e_maddr;
    } vec_t;

    vec_t tbl[$];

    instruction_fetch_unit #(.LINES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .hit             (hit),
        .addr_out        (addr_out),
        .instruction_out (instruction_out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit st, bit br, bit [31:0] tgt, bit ack, bit [31:0] rd,
                                bit e_hit, bit [31:0] e_addr, bit [31:0] e_instr,
                                bit e_req, bit [31:0] e_maddr);
        vec_t v;
        v.st = st; v.br = br; v.tgt = tgt; v.ack = ack; v.rd = rd;
        v.e_hit = e_hit; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_req = e_req; v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(input string name, input bit e_hit, input bit [31:0] e_addr,
                       input bit [31:0] e_instr, input bit e_req, input bit [31:0] e_maddr);
        checks++;
        if (hit !== e_hit || addr_out !== e_addr || instruction_out !== e_instr ||
            mem_req !== e_req || mem_addr !== e_maddr) begin
            errors++;
            $display("FAIL %s: got hit=%b addr=%h instr=%h req=%b maddr=%h, want hit=%b addr=%h instr=%h req=%b maddr=%h",
                     name, hit, addr_out, instruction_out, mem_req, mem_addr,
                     e_hit, e_addr, e_instr, e_req, e_maddr);
        end
    endtask

    // Called at a falling edge: drive the row, check, advance to the next falling edge.
    task automatic run_row(input vec_t v, input string name);
        stall         = v.st;
        branch_taken  = v.br;
        branch_target = v.tgt;
        mem_ack       = v.ack;
        mem_rdata     = v.rd;
        #1;
        chk(name, v.e_hit, v.e_addr, v.e_instr, v.e_req, v.e_maddr);
        @(negedge clk);
    endtask

    localparam bit [31:0] NOP = 32'h0000_0020;
    localparam bit [31:0] W4  = 32'h1111_0004;
    localparam bit [31:0] W8  = 32'h2222_0008;
    localparam bit [31:0] WC  = 32'h3333_000C;
    localparam bit [31:0] W40 = 32'h4444_0040;
    localparam bit [31:0] WFC = 32'h6666_FFFC;
    localparam bit [31:0] TOP = 32'hFFFF_FFFC;

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // cold miss at 0, ack after 2 cycles with the NOP-valued word
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h0,NOP,0,32'h0));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h0,NOP,1,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,NOP,           0,32'h0,NOP,1,32'h0));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h0,NOP,0,32'h0));
        // warm lines 1..3
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h4,NOP,0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,W4,            0,32'h4,NOP,1,32'h4));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h4,W4,0,32'h4));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h8,NOP,0,32'h4));
        tbl.push_back(mk(0,0,32'h0,1,W8,            0,32'h8,NOP,1,32'h8));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h8,W8,0,32'h8));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'hC,NOP,0,32'h8));
        tbl.push_back(mk(0,0,32'h0,1,WC,            0,32'hC,NOP,1,32'hC));
        tbl.push_back(mk(0,1,32'h0,0,32'h0,         1,32'hC,WC,0,32'hC));
        // back-to-back hits 0,4,8,12
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h0,NOP,0,32'hC));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h4,W4,0,32'hC));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h8,W8,0,32'hC));
        tbl.push_back(mk(0,1,32'h8,0,32'h0,         1,32'hC,WC,0,32'hC));
        // stall at 8 for 3 cycles, stray ack in LOOKUP must not write
        tbl.push_back(mk(1,0,32'h0,0,32'h0,         1,32'h8,W8,0,32'hC));
        tbl.push_back(mk(1,0,32'h0,0,32'h0,         1,32'h8,W8,0,32'hC));
        tbl.push_back(mk(1,0,32'h0,1,32'hDEADBEEF,  1,32'h8,W8,0,32'hC));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h8,W8,0,32'hC));
        tbl.push_back(mk(0,1,32'h40,0,32'h0,        1,32'hC,WC,0,32'hC));
        // miss at 0x40, redirect to 0x100 one cycle before ack
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h40,NOP,0,32'hC));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h40,NOP,1,32'h40));
        tbl.push_back(mk(0,1,32'h100,0,32'h0,       0,32'h40,NOP,1,32'h40));
        tbl.push_back(mk(0,0,32'h0,1,W40,           0,32'h40,NOP,1,32'h40));
        tbl.push_back(mk(0,1,32'h40,0,32'h0,        0,32'h100,NOP,0,32'h40));
        // 0x40 now resident; 0x00 aliases index 0 and misses, then 0x40 misses again
        tbl.push_back(mk(0,1,32'h0,0,32'h0,         1,32'h40,W40,0,32'h40));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h0,NOP,0,32'h40));
        tbl.push_back(mk(0,0,32'h0,1,NOP,           0,32'h0,NOP,1,32'h0));
        tbl.push_back(mk(0,1,32'h40,0,32'h0,        1,32'h0,NOP,0,32'h0));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h40,NOP,0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,W40,           0,32'h40,NOP,1,32'h40));
        // top-of-memory miss with two redirects during MISS (last one wins)
        tbl.push_back(mk(0,1,TOP,0,32'h0,           1,32'h40,W40,0,32'h40));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,TOP,NOP,0,32'h40));
        tbl.push_back(mk(0,1,32'h200,0,32'h0,       0,TOP,NOP,1,TOP));
        tbl.push_back(mk(0,1,32'h300,0,32'h0,       0,TOP,NOP,1,TOP));
        tbl.push_back(mk(0,0,32'h0,1,WFC,           0,TOP,NOP,1,TOP));
        tbl.push_back(mk(0,1,TOP,0,32'h0,           0,32'h300,NOP,0,TOP));
        // hit at 0xFFFFFFFC wraps PC to 0
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,TOP,WFC,0,TOP));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         0,32'h0,NOP,0,TOP));
        // pending 0x80 overridden by a branch in the ack cycle to 0xC0
        tbl.push_back(mk(0,1,32'h80,0,32'h0,        0,32'h0,NOP,1,32'h0));
        tbl.push_back(mk(0,1,32'hC0,1,NOP,          0,32'h0,NOP,1,32'h0));
        tbl.push_back(mk(0,1,32'h0,0,32'h0,         0,32'hC0,NOP,0,32'h0));
        tbl.push_back(mk(0,0,32'h0,0,32'h0,         1,32'h0,NOP,0,32'h0));

        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
        reset = 1'b1;

        foreach (tbl[i]) run_row(tbl[i], $sformatf("row%0d", i));

        // reset while a refill to 0x80 is outstanding, then a late ack
        run_row(mk(0,1,32'h80,0,32'h0, 1,32'h4,W4,0,32'h0), "pre_reset_hit");
        run_row(mk(0,0,32'h0,0,32'h0,  0,32'h80,NOP,0,32'h0), "pre_reset_miss");
        run_row(mk(0,0,32'h0,0,32'h0,  0,32'h80,NOP,1,32'h80), "pre_reset_req");
        reset = 1'b0;
        #1;
        chk("async_reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_row(mk(0,0,32'h0,1,32'h0BADF00D, 0,32'h0,NOP,0,32'h0), "late_ack");
        run_row(mk(0,0,32'h0,0,32'h0, 0,32'h0,NOP,1,32'h0), "new_miss_0");
        run_row(mk(0,0,32'h0,1,NOP,   0,32'h0,NOP,1,32'h0), "refill_0");
        run_row(mk(0,1,32'h80,0,32'h0, 1,32'h0,NOP,0,32'h0), "hit_0");
        run_row(mk(0,0,32'h0,0,32'h0, 0,32'h80,NOP,0,32'h0), "no_write_80");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
